// File: rtl/dekatron_step_sequencer.sv
// Command front-end for one dekatron digit: turns INC/DEC/SET/CLEAR into whole,
// frame-aligned En pulse frames for the two-phase pulse sender, tracking the tube position.
module dekatron_step_sequencer #(
   parameter int HSCLK_DIV = 10,
   parameter bit SHORTEST  = 1'b1
) (
   input  logic       hsClk,
   input  logic       Rst_n,
   input  logic       Request,
   input  logic [1:0] Cmd,
   input  logic [3:0] Data,
   output logic       Ready,
   output logic       En,
   output logic       Dec,
   output logic [3:0] Pos,
   output logic       Carry,
   output logic       Borrow
);

   localparam int PW = (HSCLK_DIV > 1) ? $clog2(HSCLK_DIV) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, STEP, DONE} stateT;

   // Handshake: a command is taken on a rising hsClk edge where Request and Ready are both 1;
   // Request while Ready=0 is dropped, and Cmd/Data are only looked at on that edge.
   stateT         state, nextState;
   logic [PW-1:0] phase;
   logic [3:0]    steps;
   logic          lastPhase;
   logic          accept, enRise, stepNow, lastStep;
   logic [3:0]    cmdSteps, target;
   logic          cmdDec;
   logic [4:0]    diff;

   assign lastPhase = (phase == PW'(HSCLK_DIV - 1));

   // Step count and direction for the command presented this cycle.
   always_comb begin
      cmdSteps = Data;
      cmdDec   = Cmd[0];
      target   = (Cmd == 2'b11) ? 4'd0 : Data;
      diff     = 5'd0;
      if (Cmd[1]) begin
         cmdDec   = 1'b0;
         cmdSteps = 4'd0;
         if (target <= 4'd9) begin
            diff = ({1'b0, target} >= {1'b0, Pos}) ? ({1'b0, target} - {1'b0, Pos})
                                                   : ({1'b0, target} + 5'd10 - {1'b0, Pos});
            if (SHORTEST && diff > 5'd5) begin
               cmdDec   = 1'b1;
               cmdSteps = 4'(5'd10 - diff);
            end else begin
               cmdSteps = diff[3:0];
            end
         end
      end
   end

   always_ff @(posedge hsClk or negedge Rst_n) begin
      if (!Rst_n) state <= IDLE;
      else        state <= nextState;
   end

   // A command accepted on the last phase of a frame goes straight to STEP so En still
   // rises on the very next phase 0.
   always_comb begin
      nextState = state;
      unique case (state)
         IDLE: if (accept) begin
            if (cmdSteps == 4'd0) nextState = DONE;
            else if (lastPhase)   nextState = STEP;
            else                  nextState = WAIT;
         end
         WAIT: if (lastPhase) nextState = STEP;
         STEP: if (lastStep)  nextState = DONE;
         DONE: nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      accept   = (state == IDLE) && Request && Ready;
      enRise   = ((state == WAIT) && lastPhase) ||
                 (accept && (cmdSteps != 4'd0) && lastPhase);
      stepNow  = (state == STEP) && lastPhase;
      lastStep = stepNow && (steps == 4'd1);
   end

   always_ff @(posedge hsClk or negedge Rst_n) begin
      if (!Rst_n) begin
         phase  <= '0;
         steps  <= 4'd0;
         Ready  <= 1'b1;
         En     <= 1'b0;
         Dec    <= 1'b0;
         Pos    <= 4'd0;
         Carry  <= 1'b0;
         Borrow <= 1'b0;
      end else begin
         phase  <= lastPhase ? '0 : phase + 1'b1;
         // Ready returns one cycle after the FSM is back in IDLE.
         Ready  <= (state == IDLE) && !accept;
         Carry  <= 1'b0;
         Borrow <= 1'b0;
         if (accept) begin
            steps <= cmdSteps;
            Dec   <= cmdDec;
         end
         if (enRise)   En <= 1'b1;
         if (lastStep) En <= 1'b0;
         if (stepNow) begin
            steps <= steps - 4'd1;
            if (Dec) begin
               Pos    <= (Pos == 4'd0) ? 4'd9 : Pos - 4'd1;
               Borrow <= (Pos == 4'd0);
            end else begin
               Pos   <= (Pos == 4'd9) ? 4'd0 : Pos + 4'd1;
               Carry <= (Pos == 4'd9);
            end
         end
      end
   end

endmodule

// File: tb/tb_dekatron_step_sequencer.sv
// Directed bench for dekatron_step_sequencer: one shortest-path instance and one
// increment-only instance, with hand-computed frame counts and positions.
module tb_dekatron_step_sequencer;

   logic       hsClk = 1'b0;
   logic       Rst_n;
   logic       Request0, Request1;
   logic [1:0] Cmd;
   logic [3:0] Data;
   logic       Ready0, En0, Dec0, Carry0, Borrow0;
   logic       Ready1, En1, Dec1, Carry1, Borrow1;
   logic [3:0] Pos0, Pos1;

   int nTests = 0;
   int nFail  = 0;
   int tbPhase;
   logic selDut;

   localparam logic [1:0] C_INC = 2'b00, C_DEC = 2'b01, C_SET = 2'b10, C_CLR = 2'b11;

   always #5 hsClk = ~hsClk;

   dekatron_step_sequencer #(.HSCLK_DIV(10), .SHORTEST(1'b1)) dut0 (
      .hsClk(hsClk), .Rst_n(Rst_n), .Request(Request0), .Cmd(Cmd), .Data(Data),
      .Ready(Ready0), .En(En0), .Dec(Dec0), .Pos(Pos0), .Carry(Carry0), .Borrow(Borrow0)
   );

   dekatron_step_sequencer #(.HSCLK_DIV(10), .SHORTEST(1'b0)) dut1 (
      .hsClk(hsClk), .Rst_n(Rst_n), .Request(Request1), .Cmd(Cmd), .Data(Data),
      .Ready(Ready1), .En(En1), .Dec(Dec1), .Pos(Pos1), .Carry(Carry1), .Borrow(Borrow1)
   );

   // Reference frame phase: phase 0 is the first cycle after reset release.
   always @(posedge hsClk or negedge Rst_n) begin
      if (!Rst_n) tbPhase <= 0;
      else        tbPhase <= (tbPhase == 9) ? 0 : tbPhase + 1;
   end

   logic       mReady, mEn, mDec, mCarry, mBorrow;
   logic [3:0] mPos;
   assign mReady  = selDut ? Ready1  : Ready0;
   assign mEn     = selDut ? En1     : En0;
   assign mDec    = selDut ? Dec1    : Dec0;
   assign mCarry  = selDut ? Carry1  : Carry0;
   assign mBorrow = selDut ? Borrow1 : Borrow0;
   assign mPos    = selDut ? Pos1    : Pos0;

   task automatic check(input string tag, input int got, input int exp);
      nTests++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic wait_phase(input int ph);
      int n = 0;
      @(negedge hsClk);
      while (tbPhase != ph && n < 40) begin
         @(negedge hsClk);
         n++;
      end
      check("wait_phase_bound", int'(tbPhase == ph), 1);
   endtask

   // Present one command at the given phase; the following posedge is the acceptance edge.
   task automatic send(input bit which, input logic [1:0] c, input logic [3:0] d, input int ph);
      wait_phase(ph);
      Cmd  = c;
      Data = d;
      if (which) Request1 = 1'b1;
      else       Request0 = 1'b1;
      @(posedge hsClk);
      #1;
      Request0 = 1'b0;
      Request1 = 1'b0;
   endtask

   task automatic run(input string tag, input bit which, input logic [1:0] c,
                      input logic [3:0] d, input int ph, input bit noise,
                      input int eFirst, input int eLen, input int eDecCnt, input int ePos,
                      input int eCarry, input int eBorrow, input int eReady);
      int first = 0, len = 0, decCnt = 0, carries = 0, borrows = 0, both = 0, rdy = 0;
      selDut = which;
      send(which, c, d, ph);
      for (int i = 1; i <= 200 && rdy == 0; i++) begin
         @(negedge hsClk);
         if (mEn) begin
            if (first == 0) first = i;
            len++;
            if (mDec) decCnt++;
         end
         if (mCarry)  carries++;
         if (mBorrow) borrows++;
         if (mCarry && mBorrow) both++;
         if (mReady) begin
            rdy = i;
            Request0 = 1'b0;
            Request1 = 1'b0;
         end else if (noise) begin
            Request0 = (i % 7 == 3);
         end
      end
      Request0 = 1'b0;
      check({tag, "_en_first"},  first,   eFirst);
      check({tag, "_en_len"},    len,     eLen);
      check({tag, "_dec_cycles"}, decCnt, eDecCnt);
      check({tag, "_pos"},       int'(mPos), ePos);
      check({tag, "_carry"},     carries, eCarry);
      check({tag, "_borrow"},    borrows, eBorrow);
      check({tag, "_ready_at"},  rdy,     eReady);
      check({tag, "_cb_both"},   both,    0);
   endtask

   initial begin
      Rst_n = 1'b0; Request0 = 1'b0; Request1 = 1'b0; Cmd = 2'b00; Data = 4'd0; selDut = 1'b0;
      repeat (3) @(negedge hsClk);
      Rst_n = 1'b1;
      #1;
      check("rst_ready", int'(Ready0), 1);
      check("rst_en",    int'(En0),    0);
      check("rst_dec",   int'(Dec0),   0);
      check("rst_pos",   int'(Pos0),   0);
      check("rst_carry", int'(Carry0), 0);
      check("rst_borrow", int'(Borrow0), 0);

      //   tag      dut cmd   data  ph noise first len dec pos C  B  ready
      run("inc3",    0, C_INC, 4'd3,  4, 0, 6,  30,  0, 3, 0, 0, 38);
      run("clr_3",   0, C_CLR, 4'd9,  4, 0, 6,  30, 30, 0, 0, 0, 38);
      run("dec1",    0, C_DEC, 4'd1,  0, 0, 10, 10, 10, 9, 0, 1, 22);
      run("set2_9",  0, C_SET, 4'd2,  4, 0, 6,  30,  0, 2, 1, 0, 38);
      run("set8_2",  0, C_SET, 4'd8,  4, 0, 6,  40, 40, 8, 0, 1, 48);
      run("set2_8",  0, C_SET, 4'd2,  4, 0, 6,  40,  0, 2, 1, 0, 48);
      run("set7_2",  0, C_SET, 4'd7,  4, 0, 6,  50,  0, 7, 0, 0, 58);
      run("inc0",    0, C_INC, 4'd0,  9, 0, 0,   0,  0, 7, 0, 0, 3);
      run("set12",   0, C_SET, 4'd12, 3, 0, 0,   0,  0, 7, 0, 0, 3);
      run("set5_7",  0, C_SET, 4'd5,  4, 0, 6,  20, 20, 5, 0, 0, 28);
      run("inc12",   0, C_INC, 4'd12, 9, 1, 1, 120,  0, 7, 1, 0, 123);
      run("u_set2",  1, C_SET, 4'd2,  4, 0, 6,  20,  0, 2, 0, 0, 28);
      run("u_set8",  1, C_SET, 4'd8,  4, 0, 6,  60,  0, 8, 0, 0, 68);

      // Abort mid-STEP: after one frame of INC 4 from 7, reset must drop everything at once.
      selDut = 1'b0;
      send(0, C_INC, 4'd4, 0);
      repeat (24) @(negedge hsClk);
      check("abort_pre_pos", int'(Pos0), 8);
      check("abort_pre_en",  int'(En0),  1);
      #2;
      Rst_n = 1'b0;
      #1;
      check("abort_en",     int'(En0),     0);
      check("abort_dec",    int'(Dec0),    0);
      check("abort_carry",  int'(Carry0),  0);
      check("abort_borrow", int'(Borrow0), 0);
      check("abort_pos",    int'(Pos0),    0);
      check("abort_ready",  int'(Ready0),  1);
      check("abort_pos_u",  int'(Pos1),    0);
      repeat (2) @(negedge hsClk);
      Rst_n = 1'b1;
      repeat (12) @(negedge hsClk);
      check("abort_no_en", int'(En0), 0);
      run("post_inc1", 0, C_INC, 4'd1, 4, 0, 6, 10, 0, 1, 0, 0, 18);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule

// File: doc/dekatron_step_sequencer.md
Name: dekatron_step_sequencer

Overview:
- Command front-end for one dekatron digit; sits directly upstream of the two-phase dekatron pulse sender and drives its En and Dec inputs.
- Accepts increment, decrement, set and clear commands; converts each into a whole number of 10-hsClk pulse frames, each frame aligned to the sender's free-running frame.
- Tracks the tube position (0..9) and flags carry and borrow for digit chaining.

Parameters:
- HSCLK_DIV, 10, hsClk cycles per step frame; must equal the pulse sender's HSCLK_DIV.
- SHORTEST, 1, for SET: 1 = take the shorter direction around the ring; 0 = always increment.

Ports:
- hsClk  in  1  single clock; the same clock as the pulse sender.
- Rst_n  in  1  asynchronous active-low reset; the same net as the pulse sender's reset.
- Request  in  1  command valid; accepted only in a cycle where Ready=1.
- Cmd  in  2  00 INC, 01 DEC, 10 SET, 11 CLEAR (same as SET 0).
- Data  in  4  step count for INC/DEC (0..15); target digit for SET.
- Ready  out  1  idle and able to accept a command.
- En  out  1  to the pulse sender's En; registered.
- Dec  out  1  to the pulse sender's Dec; registered; stable for the whole command.
- Pos  out  4  current digit 0..9.
- Carry  out  1  one-cycle pulse on a 9->0 step.
- Borrow  out  1  one-cycle pulse on a 0->9 step.

Behaviour:
- Clock and reset: one clock (hsClk); reset is asynchronous and active-low (Rst_n).
- Reset values: Ready=1, En=0, Dec=0, Pos=0, Carry=0, Borrow=0, phase=0, state IDLE. Reset mid-command aborts it immediately, with no further frames.
- Phase counter:
  - Free-running 0..HSCLK_DIV-1, wrapping.
  - Released from reset together with the sender, so phase 0 is the first cycle of each sender frame.
- FSM states: IDLE, WAIT, STEP, DONE.
- IDLE:
  - On Request&&Ready, latch the direction and the step count S.
  - INC: S=Data, Dec=0. DEC: S=Data, Dec=1.
  - SET/CLEAR: if the target is >9, S=0. Otherwise d=(target-Pos) mod 10.
    - If SHORTEST=1 and d>5: Dec=1, S=10-d.
    - Otherwise: Dec=0, S=d.
  - If S=0, go to DONE; otherwise go to WAIT. Ready falls in the cycle after acceptance.
- WAIT: when phase==HSCLK_DIV-1, set En<=1 and go to STEP. En is therefore high starting exactly at phase 0.
- STEP, on each cycle with phase==HSCLK_DIV-1 (end of a frame):
  - Pos<=Pos±1 mod 10.
  - Carry or Borrow pulses for one cycle on wrap.
  - S<=S-1.
  - If S was 1: En<=0, go to DONE. Otherwise stay in STEP with En held high.
  - En is therefore high for exactly S×HSCLK_DIV cycles, contiguous, frame-aligned.
- DONE: one cycle, then go to IDLE with Ready=1. Pos is valid on the same edge that clears En.
- Request while Ready=0 is ignored, with no queuing. Cmd and Data matter only in the acceptance cycle.
- Pos never leaves 0..9. Carry and Borrow are never both high.
- Latency: Request accepted at phase p (for S>0) gives En rising after (HSCLK_DIV-1-p)+1 cycles.

Test Plan:
- Reset, wait to phase 4, INC Data=3 -> En rises 6 cycles after acceptance, stays high 30 cycles with Dec=0; Pos steps 0→1→2→3 at frame ends; Ready=1 two cycles after En falls.
- From Pos=0, DEC Data=1 -> Dec=1, En high 10 cycles, Pos=9, Borrow pulses once at the frame end, Carry stays 0.
- SET 8 from Pos=2 -> Dec=1, 4 frames, Pos=8. SET 7 from Pos=2 -> Dec=0, 5 frames, Pos=7. With SHORTEST=0, SET 8 from 2 -> 6 increment frames.
- INC Data=0 and SET Data=12 -> En never asserts; Ready low for exactly 2 cycles; Pos unchanged.
- From Pos=5, INC Data=12 -> 120 En cycles, one Carry pulse (at 9→0), final Pos=7; Requests pulsed during the run are ignored.
- Assert Rst_n=0 mid-STEP (after 1 frame of INC 4) -> En, Dec, Carry and Borrow drop asynchronously; Pos=0, Ready=1; a fresh INC 1 afterwards completes normally.
